// File: rtl/uart_rx_deframer_pkg.sv
// Shared types and frame-layout helpers for the UART receive deframer.
// Frame layout: start at bit 0, data LSB-first above it, optional parity, then stop bits.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_e;

  localparam int MAX_DATA_W = 9;

  // Widest-case queue entry; narrower configurations use the low data bits.
  typedef struct packed {
    logic                  parity_err;
    logic                  frame_err;
    logic [MAX_DATA_W-1:0] data;
  } rx_entry_t;

  function automatic int frame_w(input int data_w, input int parity, input int stop_bits);
    return 1 + data_w + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

  function automatic int par_pos(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int stop_lo(input int data_w, input int parity);
    return data_w + 1 + ((parity != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word that tracks the next entry to pop.
// The head reads zero whenever the FIFO is empty.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [AW:0]      o_level,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_rd_data;

  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_wr_ptr_nxt;
  logic [AW:0]      w_rd_ptr_nxt;

  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop on a full FIFO frees the slot that a same-cycle push then fills.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  assign w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(w_push);
  assign w_rd_ptr_nxt = r_rd_ptr + (AW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  // Head register: bypass the incoming word when it becomes the new head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (w_wr_ptr_nxt == w_rd_ptr_nxt) begin
      r_rd_data <= '0;
    end else if (w_push && (r_wr_ptr[AW-1:0] == w_rd_ptr_nxt[AW-1:0])) begin
      r_rd_data <= i_wr_data;
    end else begin
      r_rd_data <= r_mem[w_rd_ptr_nxt[AW-1:0]];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: captures parallel frames, checks start/stop/parity,
// queues payload with error flags and keeps overrun and error statistics.
module uart_rx_deframer
  import uart_rx_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int PARITY    = 2,
  parameter  int STOP_BITS = 1,
  parameter  int DEPTH     = 8,
  localparam int FRAME_W   = frame_w(DATA_W, PARITY, STOP_BITS),
  localparam int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               frame_valid,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_frame_err,
  output logic               m_parity_err,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               done_flag,
  output logic               overrun,
  input  logic               clr_ovr,
  input  logic               clr_stats,
  output logic [15:0]        cnt_frame_err,
  output logic [15:0]        cnt_parity_err,
  output logic [15:0]        cnt_overrun,
  output logic [LVL_W-1:0]   level
);

  localparam int STOP_LO = stop_lo(DATA_W, PARITY);
  localparam int FIFO_W  = DATA_W + 2;

  logic [FRAME_W-1:0] r_cap_q;
  logic               r_cap_v;
  logic               r_done;
  logic               r_ovr;
  logic [15:0]        r_cnt [3];

  logic [DATA_W-1:0]  w_data;
  logic               w_frame_err;
  logic               w_parity_err;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [FIFO_W-1:0]  w_head;
  logic [2:0]         w_cnt_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_q <= '0;
      r_cap_v <= 1'b0;
    end else begin
      r_cap_v <= frame_valid;
      if (frame_valid) begin
        r_cap_q <= frame_in;
      end
    end
  end

  assign w_data      = r_cap_q[DATA_W:1];
  assign w_frame_err = r_cap_q[0] | ~(&r_cap_q[FRAME_W-1:STOP_LO]);

  generate
    if (PARITY == 0) begin : g_no_par
      assign w_parity_err = 1'b0;
    end else begin : g_par
      localparam int PAR_POS = par_pos(DATA_W);
      // XOR across data and parity bit: 1 for an odd count of ones.
      logic w_par_xor;
      assign w_par_xor    = ^r_cap_q[PAR_POS:1];
      assign w_parity_err = (PARITY == int'(ODD)) ? ~w_par_xor : w_par_xor;
    end
  endgenerate

  assign w_pop  = ~w_empty & m_ready;
  assign w_push = r_cap_v & (~w_full | w_pop);
  assign w_drop = r_cap_v & w_full & ~w_pop;

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wr_data ({w_parity_err, w_frame_err, w_data}),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_level   (level),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

  assign m_data       = w_head[DATA_W-1:0];
  assign m_frame_err  = w_head[DATA_W];
  assign m_parity_err = w_head[DATA_W+1];
  assign m_valid      = ~w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_done <= w_push;
      if (w_drop) begin
        r_ovr <= 1'b1;
      end else if (clr_ovr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign done_flag = r_done;
  assign overrun   = r_ovr;

  // Error statistics count every checked frame, including ones dropped on overrun.
  assign w_cnt_evt = {w_drop, r_cap_v & w_parity_err, r_cap_v & w_frame_err};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt[gi] <= '0;
        end else if (clr_stats) begin
          r_cnt[gi] <= '0;
        end else if (w_cnt_evt[gi] && (r_cnt[gi] != 16'hFFFF)) begin
          r_cnt[gi] <= r_cnt[gi] + 16'd1;
        end
      end
    end
  endgenerate

  assign cnt_frame_err  = r_cnt[0];
  assign cnt_parity_err = r_cnt[1];
  assign cnt_overrun    = r_cnt[2];

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomised bench for uart_rx_deframer against a queue-based reference model.
// Directed phases cover the documented frame cases, overrun, push/pop on full, reset and saturation.
module tb_uart_rx_deframer;
  import uart_rx_pkg::*;

  localparam int DATA_W    = 8;
  localparam int PARITY    = 2;
  localparam int STOP_BITS = 1;
  localparam int DEPTH     = 8;
  localparam int FRAME_W   = frame_w(DATA_W, PARITY, STOP_BITS);
  localparam int LVL_W     = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [FRAME_W-1:0] frame_in = '0;
  logic               frame_valid = 1'b0;
  logic [DATA_W-1:0]  m_data;
  logic               m_frame_err;
  logic               m_parity_err;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic               done_flag;
  logic               overrun;
  logic               clr_ovr = 1'b0;
  logic               clr_stats = 1'b0;
  logic [15:0]        cnt_frame_err;
  logic [15:0]        cnt_parity_err;
  logic [15:0]        cnt_overrun;
  logic [LVL_W-1:0]   level;

  always #5 clk = ~clk;

  uart_rx_deframer #(
    .DATA_W    (DATA_W),
    .PARITY    (PARITY),
    .STOP_BITS (STOP_BITS),
    .DEPTH     (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_in       (frame_in),
    .frame_valid    (frame_valid),
    .m_data         (m_data),
    .m_frame_err    (m_frame_err),
    .m_parity_err   (m_parity_err),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .done_flag      (done_flag),
    .overrun        (overrun),
    .clr_ovr        (clr_ovr),
    .clr_stats      (clr_stats),
    .cnt_frame_err  (cnt_frame_err),
    .cnt_parity_err (cnt_parity_err),
    .cnt_overrun    (cnt_overrun),
    .level          (level)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit quiet    = 1'b0;

  // Reference model state
  rx_entry_t          mq[$];
  bit                 m_cap_v;
  logic [FRAME_W-1:0] m_cap;
  int unsigned        m_cnt_fe, m_cnt_pe, m_cnt_ov;
  bit                 m_ovr, m_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FRAME_W-1:0] make_frame(input int data, input bit bad_par,
                                                     input bit bad_start, input bit bad_stop);
    logic [31:0] f;
    int ones;
    int p;
    ones = $countones(data);
    p = (PARITY == 1) ? ((ones % 2 == 0) ? 1 : 0) : (ones % 2);
    if (bad_par) p = 1 - p;
    f = 32'(bad_start ? 1 : 0);
    f = f + 32'(data) * 2;
    if (PARITY != 0) f = f + 32'(p) * (32'd1 << (DATA_W + 1));
    for (int i = 0; i < STOP_BITS; i++) begin
      if (!(bad_stop && i == 0)) f = f + (32'd1 << (FRAME_W - STOP_BITS + i));
    end
    return f[FRAME_W-1:0];
  endfunction

  function automatic rx_entry_t decode(input logic [FRAME_W-1:0] f);
    rx_entry_t e;
    int ones;
    e.data = MAX_DATA_W'((32'(f) / 2) % (32'd1 << DATA_W));
    e.frame_err = (f[0] != 1'b0);
    for (int i = 0; i < STOP_BITS; i++) begin
      if (f[FRAME_W-1-i] != 1'b1) e.frame_err = 1'b1;
    end
    ones = $countones(e.data);
    if (PARITY != 0) ones += int'(f[DATA_W+1]);
    e.parity_err = (PARITY == 1) ? (ones % 2 != 1) : (PARITY == 2) ? (ones % 2 != 0) : 1'b0;
    return e;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v < 32'hFFFF) ? v + 1 : v;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_cap_v = 0; m_cap = '0;
    m_cnt_fe = 0; m_cnt_pe = 0; m_cnt_ov = 0;
    m_ovr = 0; m_done = 0;
  endtask

  task automatic model_edge();
    bit pop_m, acc, drop;
    rx_entry_t e, popped;
    pop_m = (mq.size() > 0) && m_ready;
    acc = 0; drop = 0;
    e = '0;
    if (m_cap_v) begin
      e = decode(m_cap);
      if (mq.size() < DEPTH || pop_m) acc = 1; else drop = 1;
    end
    if (clr_stats) begin
      m_cnt_fe = 0; m_cnt_pe = 0; m_cnt_ov = 0;
    end else begin
      if (m_cap_v && e.frame_err)  m_cnt_fe = sat_inc(m_cnt_fe);
      if (m_cap_v && e.parity_err) m_cnt_pe = sat_inc(m_cnt_pe);
      if (drop)                    m_cnt_ov = sat_inc(m_cnt_ov);
    end
    if (drop) m_ovr = 1; else if (clr_ovr) m_ovr = 0;
    if (pop_m) begin
      popped = mq.pop_front();
      if (!quiet) $display("pop  data=%02h pe=%0d fe=%0d", popped.data, popped.parity_err, popped.frame_err);
    end
    if (acc) mq.push_back(e);
    if (drop && !quiet) $display("drop data=%02h (queue full)", e.data);
    m_done = acc;
    m_cap_v = frame_valid;
    m_cap = frame_in;
  endtask

  task automatic compare();
    rx_entry_t h;
    h = (mq.size() > 0) ? mq[0] : '0;
    check_eq("m_valid", 32'(m_valid), 32'(mq.size() != 0));
    check_eq("level", 32'(level), 32'(mq.size()));
    check_eq("m_data", 32'(m_data), 32'(h.data));
    check_eq("m_frame_err", 32'(m_frame_err), 32'(h.frame_err));
    check_eq("m_parity_err", 32'(m_parity_err), 32'(h.parity_err));
    check_eq("done_flag", 32'(done_flag), 32'(m_done));
    check_eq("overrun", 32'(overrun), 32'(m_ovr));
    check_eq("cnt_frame_err", 32'(cnt_frame_err), m_cnt_fe);
    check_eq("cnt_parity_err", 32'(cnt_parity_err), m_cnt_pe);
    check_eq("cnt_overrun", 32'(cnt_overrun), m_cnt_ov);
  endtask

  task automatic drive(input bit fv, input logic [FRAME_W-1:0] fin, input bit rdy,
                       input bit co, input bit cs);
    frame_valid = fv; frame_in = fin; m_ready = rdy; clr_ovr = co; clr_stats = cs;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, '0, rdy, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 4 && mq.size() > 0; i++) idle(1'b1);
    check_eq("drained", 32'(m_valid), 32'd0);
  endtask

  initial begin
    int sent[$];
    int d;
    model_clear();
    #1 rst = 1'b1;
    #1 compare();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Documented single frames
    drive(1'b1, 11'h54A, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("good_valid", 32'(m_valid), 32'd1);
    check_eq("good_data", 32'(m_data), 32'hA5);
    check_eq("good_done", 32'(done_flag), 32'd1);
    idle(1'b0);
    check_eq("good_done_fall", 32'(done_flag), 32'd0);
    idle(1'b1);
    drive(1'b1, 11'h74A, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("par_data", 32'(m_data), 32'hA5);
    check_eq("par_flag", 32'(m_parity_err), 32'd1);
    check_eq("par_cnt", 32'(cnt_parity_err), 32'd1);
    idle(1'b1);
    drive(1'b1, 11'h14A, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("stop_flag", 32'(m_frame_err), 32'd1);
    idle(1'b1);
    drive(1'b1, 11'h54B, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("start_flag", 32'(m_frame_err), 32'd1);
    check_eq("start_cnt", 32'(cnt_frame_err), 32'd2);
    idle(1'b1);

    // Nine frames into an eight-deep queue
    for (int i = 0; i < 9; i++) begin
      d = int'($urandom_range(0, (1 << DATA_W) - 1));
      sent.push_back(d);
      drive(1'b1, make_frame(d, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    end
    idle(1'b0);
    idle(1'b0);
    check_eq("ovr_level", 32'(level), DEPTH);
    check_eq("ovr_flag", 32'(overrun), 32'd1);
    check_eq("ovr_cnt", 32'(cnt_overrun), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_eq("ovr_clear", 32'(overrun), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("drain_order", 32'(m_data), 32'(sent[i]));
      idle(1'b1);
    end
    check_eq("drain_empty", 32'(m_valid), 32'd0);

    // Push and pop on the same edge while full
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, make_frame(int'($urandom_range(0, 255)), 0, 0, 0), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    drive(1'b1, make_frame(8'h3C, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    check_eq("full_swap_level", 32'(level), DEPTH);
    check_eq("full_swap_ovr", 32'(overrun), 32'd0);
    drain();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit fv;
      fv = ($urandom_range(0, 9) < 7);
      drive(fv,
            make_frame(int'($urandom_range(0, (1 << DATA_W) - 1)),
                       $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
                       $urandom_range(0, 99) < 10),
            $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 2);
    end
    drain();

    // Reset with three queued entries and one frame in capture
    for (int i = 0; i < 3; i++)
      drive(1'b1, make_frame(int'($urandom_range(0, 255)), 0, 0, 0), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    drive(1'b1, make_frame(8'h77, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    frame_valid = 1'b0; frame_in = '0;
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_eq("rst_valid", 32'(m_valid), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_data", 32'(m_data), 32'd0);
    compare();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    drive(1'b1, make_frame(8'h5A, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("post_rst_level", 32'(level), 32'd1);
    check_eq("post_rst_data", 32'(m_data), 32'h5A);
    drain();

    // Counter saturation and clear priority
    idle(1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    quiet = 1'b1;
    for (int i = 0; i < 32'h10005; i++)
      drive(1'b1, make_frame(int'($urandom_range(0, 255)), 1, 0, 0), 1'b1, 1'b0, 1'b0);
    drive(1'b1, make_frame(8'h81, 1, 0, 0), 1'b1, 1'b0, 1'b0);
    check_eq("sat_value", 32'(cnt_parity_err), 32'hFFFF);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check_eq("sat_clear", 32'(cnt_parity_err), 32'd0);
    quiet = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
